ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Front end of the piano datapath.
- Receives raw PS/2 keyboard frames, checks framing and parity, and tracks make, break (F0) and extended (E0) prefixes.
- Maps scan codes to note indices and presents them on oKey_Code to the play controller.
- oKey_Code = 99 means "silent": no mapped key is held.

Parameters:
- FILTER_LEN, 8: consecutive identical iClk samples required before a filtered PS/2 clock level changes.
- TIMEOUT_CYCLES, 100000: maximum iClk cycles between falling edges inside a frame before it is aborted (2 ms at 50 MHz).

Ports:
- iClk  in  1  system clock.
- iReset_n  in  1  reset. Asynchronous, active-low. Clock is iClk.
- iPs2_Clk  in  1  raw PS/2 clock, asynchronous to iClk.
- iPs2_Dat  in  1  raw PS/2 data, asynchronous to iClk.
- oKey_Code  out  8  current note index: 1..21, or 99 for silent.
- oKey_Valid  out  1  one-cycle pulse when oKey_Code changes value.
- oFrame_Err  out  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset values: oKey_Code=99, oKey_Valid=0, oFrame_Err=0. FSM in IDLE; held-key, break and extended flags cleared; filter output high.
- Input conditioning:
  - iPs2_Clk and iPs2_Dat each pass through a 2-flop synchronizer.
  - The clock then passes the FILTER_LEN glitch filter.
  - A falling edge is a single-cycle pulse fe when the filtered clock goes 1->0.
  - Data is sampled from the synchronized data on the fe cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on fe with data=0 (start bit), go to DATA and clear the bit counter. On fe with data=1, ignore and stay in IDLE; no error.
  - DATA: shift in LSB first. After the 8th fe, go to PARITY.
  - PARITY: capture the bit. Parity is odd: data bits plus parity bit must have an odd count of ones.
  - STOP: on fe, if parity is ok and stop=1, raise byte_rdy the next cycle. Otherwise pulse oFrame_Err and discard the byte. Either way, return to IDLE.
  - Timeout: in any non-IDLE state, a counter resets on each fe. If it reaches TIMEOUT_CYCLES, pulse oFrame_Err, go to IDLE and discard partial data.
  - Any frame error also clears the break and extended flags.
- Byte decoder: acts on the byte_rdy cycle, with results registered one cycle later.
  - 0xE0: set the extended flag.
  - 0xF0: set the break flag.
  - Other byte with extended set: ignored; clear both flags.
  - Make code, mapped: if the note differs from oKey_Code, load it, pulse oKey_Valid and record the held scan code. Typematic repeats of the same key produce no pulse. Pressing a new mapped key while another is held switches to the new note (last-key priority).
  - Break code equal to the held scan code: oKey_Code=99, pulse oKey_Valid, clear held.
  - Break code for any other key: ignored.
  - Both flags clear after any non-prefix byte.
  - Unmapped make codes: ignored; oKey_Code is unchanged.
- Note map:
  - Z X C V B N M (1A 22 21 2A 32 31 3A) -> 1..7
  - A S D F G H J (1C 1B 23 2B 34 33 3B) -> 8..14
  - Q W E R T Y U (15 1D 24 2D 2C 35 3C) -> 15..21
- Latency: oKey_Code and oKey_Valid update exactly 2 iClk cycles after the stop-bit fe cycle.
- Reset mid-frame: all state returns to reset values immediately. The next frame must start from a fresh start bit.
- Simultaneous events: a timeout and an fe in the same cycle are resolved in favour of fe (counter resets). oFrame_Err and oKey_Valid can never coincide.

Decomposition:
- Package piano_pkg holds:
  - NOTE_SILENT=8'd99
  - SC_BREAK=8'hF0, SC_EXT=8'hE0
  - note index localparams
  - function scan_to_note(scan) returning a note, or 0 when unmapped
- One sub-module, ps2_rx_frame: synchronizer, filter, frame FSM, timeout. It outputs byte, byte_rdy and frame_err.
- The top level holds the prefix/held-key decoder and the output registers.

Test Plan:
- Send frame 0x1C (valid parity) -> oKey_Code=8 and a 1-cycle oKey_Valid, 2 cycles after the stop fe.
- Send 1C, 1C, 1C (typematic), then F0 1C -> oKey_Valid pulses once on press; oKey_Code=99 plus one pulse on release.
- Press 15 (->15), press 3A (->7), send F0 15 -> oKey_Code stays 7. Then F0 3A -> 99.
- Frame 0x23 with parity flipped -> oFrame_Err pulse; oKey_Code stays 99. Next valid 0x23 -> 10.
- Set TIMEOUT_CYCLES=200 and stop the clock after 4 data bits -> oFrame_Err pulse about 200 cycles after the last fe. Following frame 0x1A -> 1.
- Send E0 1C -> no change. Send 0x0D (unmapped) -> no change. A 3-cycle glitch on iPs2_Clk is rejected. Assert reset mid-frame -> outputs go to 99/0/0.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: shared scan codes, note indices and the PS/2 scan-code-to-note map
package piano_pkg;

  localparam logic [7:0] NOTE_SILENT = 8'd99;
  localparam logic [7:0] NOTE_NONE   = 8'd0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;

  localparam logic [7:0] NOTE_LOW_BASE  = 8'd1;
  localparam logic [7:0] NOTE_MID_BASE  = 8'd8;
  localparam logic [7:0] NOTE_HIGH_BASE = 8'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  // Bottom row Z..M, middle row A..J, top row Q..U; anything else is unmapped (0)
  function automatic logic [7:0] scan_to_note(input logic [7:0] scan);
    case (scan)
      8'h1A: scan_to_note = NOTE_LOW_BASE + 8'd0;
      8'h22: scan_to_note = NOTE_LOW_BASE + 8'd1;
      8'h21: scan_to_note = NOTE_LOW_BASE + 8'd2;
      8'h2A: scan_to_note = NOTE_LOW_BASE + 8'd3;
      8'h32: scan_to_note = NOTE_LOW_BASE + 8'd4;
      8'h31: scan_to_note = NOTE_LOW_BASE + 8'd5;
      8'h3A: scan_to_note = NOTE_LOW_BASE + 8'd6;
      8'h1C: scan_to_note = NOTE_MID_BASE + 8'd0;
      8'h1B: scan_to_note = NOTE_MID_BASE + 8'd1;
      8'h23: scan_to_note = NOTE_MID_BASE + 8'd2;
      8'h2B: scan_to_note = NOTE_MID_BASE + 8'd3;
      8'h34: scan_to_note = NOTE_MID_BASE + 8'd4;
      8'h33: scan_to_note = NOTE_MID_BASE + 8'd5;
      8'h3B: scan_to_note = NOTE_MID_BASE + 8'd6;
      8'h15: scan_to_note = NOTE_HIGH_BASE + 8'd0;
      8'h1D: scan_to_note = NOTE_HIGH_BASE + 8'd1;
      8'h24: scan_to_note = NOTE_HIGH_BASE + 8'd2;
      8'h2D: scan_to_note = NOTE_HIGH_BASE + 8'd3;
      8'h2C: scan_to_note = NOTE_HIGH_BASE + 8'd4;
      8'h35: scan_to_note = NOTE_HIGH_BASE + 8'd5;
      8'h3C: scan_to_note = NOTE_HIGH_BASE + 8'd6;
      default: scan_to_note = NOTE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes and filters the PS/2 lines, deframes 11-bit frames with odd parity and timeout
module ps2_rx_frame
  import piano_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_rdy_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  frame_state_e  state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q, rx_byte_q;
  logic          par_q, byte_rdy_q, frame_err_q;
  logic [TW-1:0] tmo_q;
  logic          fe, dat, par_ok;

  assign fe     = filt_prev_q & ~filt_q;
  assign dat    = dat_sync_q[1];
  assign par_ok = ^{shift_q, par_q};

  assign rx_byte_o   = rx_byte_q;
  assign byte_rdy_o  = byte_rdy_q;
  assign frame_err_o = frame_err_q;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  // Glitch filter: the level flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FMAX) begin
        filt_q <= ~filt_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  // Frame FSM with inter-edge timeout; a timeout loses to a falling edge in the same cycle
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      rx_byte_q   <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tmo_q       <= (state_q == ST_IDLE || fe) ? '0 : tmo_q + 1'b1;
      case (state_q)
        ST_IDLE: if (fe && !dat) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= '0;
        end
        ST_DATA: if (fe) begin
          shift_q   <= {dat, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
        end
        ST_PARITY: if (fe) begin
          par_q   <= dat;
          state_q <= ST_STOP;
        end
        ST_STOP: if (fe) begin
          state_q <= ST_IDLE;
          if (par_ok && dat) begin
            rx_byte_q  <= shift_q;
            byte_rdy_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (state_q != ST_IDLE && !fe && tmo_q == TMAX) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 make/break/extended byte streams into a held piano note index
module ps2_key_decoder
  import piano_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Dat,
  output logic [7:0] oKey_Code,
  output logic       oKey_Valid,
  output logic       oFrame_Err
);

  logic [7:0] rx_byte, note;
  logic       byte_rdy, frame_err;
  logic       ext_q, brk_q, valid_q, err_q;
  logic [7:0] held_q, key_q;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .ps2_clk_i   (iPs2_Clk),
    .ps2_dat_i   (iPs2_Dat),
    .rx_byte_o   (rx_byte),
    .byte_rdy_o  (byte_rdy),
    .frame_err_o (frame_err)
  );

  assign note       = scan_to_note(rx_byte);
  assign oKey_Code  = key_q;
  assign oKey_Valid = valid_q;
  assign oFrame_Err = err_q;

  // Prefix tracking and held-key decode; errors are delayed one cycle so they align with key updates
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= '0;
      key_q   <= NOTE_SILENT;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= frame_err;
      if (frame_err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_rdy) begin
        if (rx_byte == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!ext_q && brk_q && held_q != 8'h00 && rx_byte == held_q) begin
            key_q   <= NOTE_SILENT;
            valid_q <= 1'b1;
            held_q  <= '0;
          end else if (!ext_q && !brk_q && note != NOTE_NONE) begin
            held_q <= rx_byte;
            if (note != key_q) begin
              key_q   <= note;
              valid_q <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
